tx_dispatch: RTL
================

Name: tx_dispatch

Overview:
- Transmit-side dispatcher of the router; the reader counterpart of the RX arbiter that pushes received flits into the router FIFO.
- Pops one flit at a time from the router FIFO and looks up its output direction in the external routing table.
- Presents the flit on exactly one of five output channels (N, S, E, W, Local) using a 4-phase req/ack handshake toward the TX transceivers.

Parameters:
- SIZE, 8, flit width in bits; also the routing-table address width.
- BITS_DIR, 3, width of the direction code returned by the routing table.
- ID, -1, router id; used only in trace/diagnostic output.
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only when TX_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  router FIFO has no entries.
- fifo_read  output  1  one-cycle pop strobe to the FIFO.
- fifo_data_out  input  SIZE  FIFO head; valid the cycle after the fifo_read pulse.
- table_addr  output  SIZE  routing-table address; equals the captured flit.
- table_data  input  BITS_DIR  combinational table result: 0=N, 1=S, 2=E, 3=W, 4=Local.
- tx_req  output  5  per-port request; bit 0 N, 1 S, 2 E, 3 W, 4 Local.
- tx_ack  input  5  per-port acknowledge from the TX transceivers.
- tx_data  output  5*SIZE  flattened per-port data; port k occupies bits [k*SIZE +: SIZE].
- drop_count  output  8  saturating count of flits dropped because of an invalid direction.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs and registers are 0, state is IDLE, and any in-flight flit is discarded.
- Release of reset takes effect at the next clk edge.
- All outputs are registered, except table_addr, which is driven straight from flit_reg (also a register).
- FSM states: IDLE, LOAD, LOOKUP, REQ, REL.
- IDLE:
  - If fifo_empty=0 at the edge: fifo_read=1 for exactly one cycle, then go to LOAD.
  - Otherwise stay in IDLE with fifo_read=0.
- LOAD: capture fifo_data_out into flit_reg, then go to LOOKUP.
- LOOKUP: sample table_data into dir_reg.
  - If table_data > 4: drop the flit, increment drop_count (saturating at 255), and return to IDLE.
  - Otherwise go to REQ. At this transition, register tx_data[dir] = flit_reg and tx_req[dir] = 1.
- REQ: hold tx_req[dir]=1 and keep tx_data[dir] stable. On tx_ack[dir]=1, clear tx_req[dir] and go to REL.
- REL: wait for tx_ack[dir]=0, then go to IDLE.
- Latency: tx_req rises 3 edges after the edge at which fifo_empty=0 is sampled in IDLE.
- Throughput: one flit per 5 cycles minimum, since a zero-latency ack still incurs one cycle each in REQ and REL.
- Only one tx_req bit is ever high at a time.
- tx_data for non-selected ports holds its last value; its content is undefined by protocol.
- tx_ack bits of non-selected ports are ignored in every state.
- tx_ack[dir] already high on entry to REQ counts as the ack; the 4-phase sequence still completes through REL.
- fifo_read is never asserted outside IDLE. fifo_empty is ignored outside IDLE.
- No pop occurs while a flit is held, so the block never underflows the FIFO.
- Reset asserted in REQ or REL: tx_req drops to 0 immediately (asynchronous) and the FSM restarts in IDLE.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counter clears on entry to REQ or REL and increments each cycle spent in either state.
  - If it reaches TIMEOUT_CYCLES: clear tx_req, abandon the flit, increment an 8-bit saturating output timeout_count, and return to IDLE.
  - A late ack arriving in IDLE is ignored.
- Not defined:
  - No watchdog and no timeout_count port.
  - REQ and REL wait indefinitely.

Test Plan:
- Reset: assert reset mid-REQ with tx_req[2]=1 -> tx_req=0, fifo_read=0, drop_count=0, busy=0 with no clk edge needed.
- Single flit: FIFO holds 8'h2A, table returns 2 -> fifo_read pulses once; tx_req=5'b00100 3 edges later; tx_data[2*8+:8]=8'h2A; after ack high then low, FSM back in IDLE.
- All ports: five flits 8'h01..8'h05 with table mapping to dirs 0..4 and immediate ack -> tx_req one-hot in order 00001, 00010, 00100, 01000, 10000; no overlap.
- Invalid direction: table returns 6 for flit 8'h77 -> no tx_req; drop_count 0->1; next flit dispatched normally.
- Stalled ack: dir 1 with ack held low for 20 cycles -> tx_req[1] held and tx_data stable; no fifo_read while non-empty; ack on port 3 ignored.
- TX_TIMEOUT_EN with TIMEOUT_CYCLES=10, ack never asserted -> tx_req drops after 10 cycles in REQ; timeout_count=1; FSM back in IDLE.

Source files
------------

// File: rtl/tx_dispatch.sv
// tx_dispatch: pops flits from the router FIFO, routes each through the external table
// and offers it on one of five TX ports with a 4-phase req/ack handshake.
// Optional ack watchdog and timeout_count port: define TX_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a non-empty FIFO; issues the one-cycle pop strobe
// LOAD   | FIFO head captured into flit_reg
// LOOKUP | table result sampled; valid dir raises tx_req, invalid dir drops the flit
// REQ    | tx_req[dir] held until tx_ack[dir] rises
// REL    | waiting for tx_ack[dir] to fall before taking the next flit
module tx_dispatch #(
  parameter int SIZE           = 8,
  parameter int BITS_DIR       = 3,
  parameter int ID             = -1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic [SIZE-1:0]       fifo_data_out,
  output logic [SIZE-1:0]       table_addr,
  input  logic [BITS_DIR-1:0]   table_data,
  output logic [4:0]            tx_req,
  input  logic [4:0]            tx_ack,
  output logic [5*SIZE-1:0]     tx_data,
  output logic [7:0]            drop_count,
  output logic                  busy
`ifdef TX_TIMEOUT_EN
  ,
  output logic [7:0]            timeout_count
`endif
);

  // Direction codes must reach Local (4), the watchdog is 8 bits, ids are -1 or >= 0.
  if (BITS_DIR < 3 || SIZE < 1 || ID < -1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255)
  begin : g_param_check
    $error("tx_dispatch: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOOKUP,
    REQ,
    REL
  } state_t;

  localparam logic [BITS_DIR-1:0] DIR_MAX = BITS_DIR'(4);

  state_t               state, state_nxt;
  logic [SIZE-1:0]      flit_reg, flit_nxt;
  logic [BITS_DIR-1:0]  dir_reg, dir_nxt;
  logic                 fifo_read_nxt;
  logic [4:0]           tx_req_nxt;
  logic [5*SIZE-1:0]    tx_data_nxt;
  logic [7:0]           drop_nxt;
  logic                 busy_nxt;
  logic [4:0]           sel;
  logic                 ack_hit;

`ifdef TX_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_cnt, wd_nxt;
  logic [7:0] tmo_nxt;
`endif

  assign table_addr = flit_reg;

  // Only the selected port's ack matters; all other ack bits are masked off.
  assign sel     = 5'd1 << dir_reg;
  assign ack_hit = |(tx_ack & sel);

  always_comb begin
    state_nxt     = state;
    flit_nxt      = flit_reg;
    dir_nxt       = dir_reg;
    fifo_read_nxt = 1'b0;
    tx_req_nxt    = tx_req;
    tx_data_nxt   = tx_data;
    drop_nxt      = drop_count;
`ifdef TX_TIMEOUT_EN
    wd_nxt        = wd_cnt;
    tmo_nxt       = timeout_count;
`endif

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_read_nxt = 1'b1;
          state_nxt     = LOAD;
        end
      end

      LOAD: begin
        flit_nxt  = fifo_data_out;
        state_nxt = LOOKUP;
      end

      LOOKUP: begin
        dir_nxt = table_data;
        if (table_data > DIR_MAX) begin
          if (drop_count != 8'hFF) drop_nxt = drop_count + 8'd1;
          state_nxt = IDLE;
        end else begin
          for (int k = 0; k < 5; k++) begin
            if (table_data == BITS_DIR'(k)) tx_data_nxt[k*SIZE +: SIZE] = flit_reg;
          end
          tx_req_nxt = 5'd1 << table_data;
          state_nxt  = REQ;
`ifdef TX_TIMEOUT_EN
          wd_nxt     = '0;
`endif
        end
      end

      REQ: begin
        if (ack_hit) begin
          tx_req_nxt = '0;
          state_nxt  = REL;
`ifdef TX_TIMEOUT_EN
          wd_nxt     = '0;
`endif
        end
`ifdef TX_TIMEOUT_EN
        else if (wd_cnt == WD_LAST) begin
          tx_req_nxt = '0;
          state_nxt  = IDLE;
          if (timeout_count != 8'hFF) tmo_nxt = timeout_count + 8'd1;
        end else begin
          wd_nxt = wd_cnt + 8'd1;
        end
`endif
      end

      REL: begin
        if (!ack_hit) begin
          state_nxt = IDLE;
        end
`ifdef TX_TIMEOUT_EN
        else if (wd_cnt == WD_LAST) begin
          state_nxt = IDLE;
          if (timeout_count != 8'hFF) tmo_nxt = timeout_count + 8'd1;
        end else begin
          wd_nxt = wd_cnt + 8'd1;
        end
`endif
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      flit_reg   <= '0;
      dir_reg    <= '0;
      fifo_read  <= 1'b0;
      tx_req     <= '0;
      tx_data    <= '0;
      drop_count <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      flit_reg   <= flit_nxt;
      dir_reg    <= dir_nxt;
      fifo_read  <= fifo_read_nxt;
      tx_req     <= tx_req_nxt;
      tx_data    <= tx_data_nxt;
      drop_count <= drop_nxt;
      busy       <= busy_nxt;
    end
  end

`ifdef TX_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt        <= '0;
      timeout_count <= '0;
    end else begin
      wd_cnt        <= wd_nxt;
      timeout_count <= tmo_nxt;
    end
  end
`endif

endmodule
